gbf_refill_ctrl: RTL and testbench

Sequences refills of the four global buffers (actv gbf1/gbf2, wgt gbf1/gbf2) through their port-a write interfaces. It takes the accelerator's need_data requests, arbitrates them round-robin, and fetches a fill stream from the off-chip source. It writes FILL_LINES words into the granted buffer, then raises that buffer's ready flag. It sits between the off-chip data source and accelerator_w_o_sram, and drives the signals currently tied off at the port level.

---
 rtl/gbf_pkg.sv | 12 +
 rtl/rr_arb4.sv | 22 ++
 rtl/gbf_refill_ctrl.sv | 126 ++++++++++++
 tb/tb_gbf_refill_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gbf_pkg.sv
// Shared constants for the global-buffer refill sequencer: buffer indices and
// the controller state encoding.
package gbf_pkg;
  localparam int NUM_BUF = 4;

  localparam logic [1:0] ACTV1 = 2'd0;
  localparam logic [1:0] ACTV2 = 2'd1;
  localparam logic [1:0] WGT1  = 2'd2;
  localparam logic [1:0] WGT2  = 2'd3;

  typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, FIN} state_e;
endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter: grants the first set request at or above ptr,
// wrapping past bit 3 back to bit 0. Purely combinational.
module rr_arb4 import gbf_pkg::*; (
  input  logic [NUM_BUF-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_BUF-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               any
);
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (!any && req[ptr + 2'(k)]) begin
        any                    = 1'b1;
        grant_idx              = ptr + 2'(k);
        grant[ptr + 2'(k)]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gbf_refill_ctrl.sv
// Refill sequencer for the four global buffers: arbitrates need_data rises,
// requests a fill stream, writes FILL_LINES words through port a, flags ready.
module gbf_refill_ctrl import gbf_pkg::*; #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int FILL_LINES        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_BUF-1:0]           need_data,
  input  logic                         finish_req,
  output logic                         req_valid,
  output logic [1:0]                   req_buf,
  input  logic                         req_ack,
  input  logic                         src_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic [NUM_BUF-1:0]           gbf_en,
  output logic [NUM_BUF-1:0]           gbf_we,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
  output logic [NUM_BUF-1:0]           buf_ready,
  output logic                         gbf_actv_data_avail,
  output logic                         gbf_wgt_data_avail,
  output logic                         finish
);
  // One extra count bit so FILL_LINES == 2^ADDR still has a distinct last value.
  localparam int              CW   = GBF_ADDR_BITWIDTH + 1;
  localparam logic [CW-1:0]   LAST = CW'(FILL_LINES - 1);

  state_e               r_state;
  logic [NUM_BUF-1:0]   r_pend;
  logic [NUM_BUF-1:0]   r_nd_q;
  logic [1:0]           r_ptr;
  logic [1:0]           r_g;
  logic [CW-1:0]        r_cnt;

  logic [NUM_BUF-1:0]   w_grant;
  logic [1:0]           w_gidx;
  logic                 w_any;
  logic                 w_take;
  logic [NUM_BUF-1:0]   w_clr;
  logic [NUM_BUF-1:0]   w_rise;

  rr_arb4 u_arb (
    .req       (r_pend),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  // A rise in the grant cycle survives the clear, so the buffer is refilled later.
  assign w_rise = need_data & ~r_nd_q;
  assign w_take = (r_state == IDLE) && !finish_req && w_any;
  assign w_clr  = w_take ? w_grant : '0;

  assign gbf_en              = gbf_we;
  assign gbf_actv_data_avail = buf_ready[ACTV1] | buf_ready[ACTV2];
  assign gbf_wgt_data_avail  = buf_ready[WGT1]  | buf_ready[WGT2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_nd_q     <= '0;
      r_ptr      <= '0;
      r_g        <= '0;
      r_cnt      <= '0;
      req_valid  <= 1'b0;
      req_buf    <= '0;
      src_ready  <= 1'b0;
      gbf_we     <= '0;
      gbf_addr   <= '0;
      gbf_w_data <= '0;
      buf_ready  <= '0;
      finish     <= 1'b0;
    end else begin
      r_nd_q <= need_data;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      gbf_we <= '0;
      case (r_state)
        IDLE: begin
          if (finish_req) begin
            finish  <= 1'b1;
            r_state <= FIN;
          end else if (w_any) begin
            r_g       <= w_gidx;
            r_ptr     <= w_gidx + 2'd1;
            buf_ready <= buf_ready & ~w_grant;
            req_valid <= 1'b1;
            req_buf   <= w_gidx;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (req_ack) begin
            req_valid <= 1'b0;
            src_ready <= 1'b1;
            r_cnt     <= '0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (src_valid) begin
            gbf_we     <= NUM_BUF'(1) << r_g;
            gbf_addr   <= r_cnt[GBF_ADDR_BITWIDTH-1:0];
            gbf_w_data <= src_data;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              src_ready <= 1'b0;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          // Last write is on the port this cycle; ready follows one cycle later.
          buf_ready <= buf_ready | (NUM_BUF'(1) << r_g);
          r_state   <= IDLE;
        end
        FIN:     ;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gbf_refill_ctrl.sv
// Bench for gbf_refill_ctrl: table-driven fills, hand-written corner sequences
// and randomized requests checked against a queue/arithmetic reference model.
module tb_gbf_refill_ctrl;
  localparam int DW = 64;
  localparam int AW = 2;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    need_data;
  logic          finish_req;
  logic          req_valid;
  logic [1:0]    req_buf;
  logic          req_ack;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic [3:0]    gbf_en, gbf_we, buf_ready;
  logic [AW-1:0] gbf_addr;
  logic [DW-1:0] gbf_w_data;
  logic          gbf_actv_data_avail, gbf_wgt_data_avail, finish;

  gbf_refill_ctrl #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .FILL_LINES(FL)) dut (
    .clk(clk), .reset(reset), .need_data(need_data), .finish_req(finish_req),
    .req_valid(req_valid), .req_buf(req_buf), .req_ack(req_ack),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .gbf_en(gbf_en), .gbf_we(gbf_we), .gbf_addr(gbf_addr), .gbf_w_data(gbf_w_data),
    .buf_ready(buf_ready), .gbf_actv_data_avail(gbf_actv_data_avail),
    .gbf_wgt_data_avail(gbf_wgt_data_avail), .finish(finish)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending set, round-robin pointer, ready flags.
  logic [3:0] m_pend, m_ready;
  int         m_ptr;

  function automatic int pick();
    for (int k = 0; k < 4; k++)
      if (m_pend[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ready = '0; m_ptr = 0;
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Write log captured from the port-a bus.
  typedef struct { logic [1:0] b; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [3:0]    prev_we, prev_rdy;
  logic [AW-1:0] prev_addr;

  always @(negedge clk) begin
    if (!reset) begin
      prev_we = '0; prev_rdy = '0; prev_addr = '0;
    end else begin
      chk("en_eq_we", gbf_en, gbf_we);
      chk("we_onehot0", 64'($onehot0(gbf_we)), 64'd1);
      chk("avail", {gbf_actv_data_avail, gbf_wgt_data_avail}, {|buf_ready[1:0], |buf_ready[3:2]});
      if (gbf_we != '0) wq.push_back('{b: oh2i(gbf_we), a: gbf_addr, d: gbf_w_data});
      for (int b = 0; b < 4; b++)
        if (buf_ready[b] && !prev_rdy[b]) begin
          chk("rdy_after_last_write_buf", prev_we, 64'(1 << b));
          chk("rdy_after_last_write_addr", prev_addr, 64'(FL - 1));
        end
      prev_we = gbf_we; prev_rdy = buf_ready; prev_addr = gbf_addr;
    end
  end

  task automatic raise(input logic [3:0] m);
    @(negedge clk); need_data = m; m_pend |= m;
    @(negedge clk); need_data = '0;
  endtask

  task automatic rst_check(input string nm);
    chk({nm, "_ctl"}, {req_valid, req_buf, src_ready, gbf_en, gbf_we, gbf_addr, buf_ready,
                       gbf_actv_data_avail, gbf_wgt_data_avail, finish}, 64'd0);
    chk({nm, "_wdata"}, gbf_w_data, 64'd0);
  endtask

  // Acts as the off-chip source for one fill of buffer eb.
  task automatic serve(input int eb, input int ack_dly, input logic [15:0] vpat,
                       input logic [3:0] mid, input bit fin);
    logic [DW-1:0] exp_d[$];
    int sent, idx;
    bit seen;
    wq.delete();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req_valid; end
    chk("req_seen", seen, 1);
    if (!seen) return;
    chk("req_buf", req_buf, 64'(eb));
    chk("ready_cleared_at_grant", buf_ready[eb], 0);
    m_pend[eb] = 1'b0; m_ptr = (eb + 1) % 4; m_ready[eb] = 1'b0;
    repeat (ack_dly) begin
      src_valid = 1'($urandom); src_data = {$urandom, $urandom};
      @(negedge clk);
      chk("req_hold", {req_valid, req_buf, src_ready, gbf_we}, {1'b1, 2'(eb), 1'b0, 4'b0});
    end
    req_ack = 1'b1;
    @(negedge clk);
    req_ack = 1'b0;
    chk("req_drop_after_ack", req_valid, 0);
    chk("src_ready_on", src_ready, 1);
    sent = 0; idx = 0;
    while (sent < FL && idx < 200) begin
      if (idx == 0) begin need_data = mid; m_pend |= mid; if (fin) finish_req = 1'b1; end
      if (idx == 1) need_data = '0;
      src_valid = src_ready ? vpat[idx % 16] : 1'b0;
      src_data  = {$urandom, $urandom};
      if (src_valid) begin exp_d.push_back(src_data); sent++; end
      idx++;
      @(negedge clk);
    end
    need_data = '0;
    chk("beats_sent", sent, FL);
    chk("src_ready_off", src_ready, 0);
    src_valid = 1'b1; src_data = '1;
    @(negedge clk);
    src_valid = 1'b0;
    seen = buf_ready[eb];
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = buf_ready[eb]; end
    chk("ready_set", seen, 1);
    m_ready[eb] = 1'b1;
    chk("n_writes", wq.size(), FL);
    for (int i = 0; i < wq.size() && i < FL; i++) begin
      chk("wr_buf", wq[i].b, 64'(eb));
      chk("wr_addr", wq[i].a, 64'(i));
      chk("wr_data", wq[i].d, exp_d[i]);
    end
    chk("ready_vec", buf_ready, m_ready);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; model_reset();
    @(negedge clk); @(negedge clk); reset = 1'b1;
  endtask

  typedef struct { logic [3:0] rise; int ack; logic [15:0] vpat; int eb; logic [3:0] er; } vec_t;
  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vt[0] = '{4'b0001, 2, 16'hFFFF, 0, 4'b0001};
    vt[1] = '{4'b0100, 0, 16'h0059, 2, 4'b0101};
    vt[2] = '{4'b0100, 1, 16'hAAAA, 2, 4'b0101};
    vt[3] = '{4'b1000, 3, 16'h3333, 3, 4'b1101};
    vt[4] = '{4'b0010, 0, 16'hFFFF, 1, 4'b1111};

    reset = 1'b0; need_data = '0; finish_req = 1'b0; req_ack = 1'b0;
    src_valid = 1'b0; src_data = '0;
    model_reset();
    #12 rst_check("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 5; t++) begin
      raise(vt[t].rise);
      serve(vt[t].eb, vt[t].ack, vt[t].vpat, 4'b0, 1'b0);
      chk("tbl_ready", buf_ready, vt[t].er);
    end

    // Round-robin: simultaneous rise on all four, then bits 0 and 2.
    do_reset();
    raise(4'b1111);
    for (int k = 0; k < 4; k++) serve(k, 1, 16'hFFFF, 4'b0, 1'b0);
    raise(4'b0101);
    serve(0, 0, 16'hFFFF, 4'b0, 1'b0);
    serve(2, 0, 16'hFFFF, 4'b0, 1'b0);

    // Randomized requests, stalls and re-requests during fills.
    for (int it = 0; (it < 12 || m_pend != '0) && it < 40; it++) begin
      if (m_pend == '0) raise(4'($urandom_range(1, 15)));
      serve(pick(), $urandom_range(0, 3), 16'($urandom) | 16'h1,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0, 1'b0);
    end

    // Async reset in the middle of a fill.
    do_reset();
    raise(4'b0010);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req_valid; end
    chk("abort_req_seen", seen, 1);
    req_ack = 1'b1; @(negedge clk); req_ack = 1'b0;
    src_valid = 1'b1; src_data = 64'h1111_2222_3333_4444; @(negedge clk);
    src_data = 64'h5555_6666_7777_8888; @(negedge clk);
    src_valid = 1'b0;
    chk("abort_pre_we", gbf_we, 4'b0010);
    #2 reset = 1'b0; model_reset();
    #1 rst_check("abort_async");
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_flag", {buf_ready, req_valid}, 5'b0);
    raise(4'b0001);
    serve(0, 1, 16'hFFFF, 4'b0, 1'b0);

    // finish_req mid-fill with buffer 2 pending.
    raise(4'b0010);
    serve(1, 0, 16'hFFFF, 4'b0100, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("fin_state", {finish, req_valid, src_ready, gbf_we}, {1'b1, 1'b0, 1'b0, 4'b0});
    end
    raise(4'b1000);
    repeat (4) begin
      @(negedge clk);
      chk("fin_ignore_need", {finish, req_valid, gbf_we}, {1'b1, 1'b0, 4'b0});
    end
    chk("fin_ready_vec", buf_ready, m_ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
